// File: rtl/tqvp_ptc_pkg.sv
// Shared definitions for the multi-channel PWM timer/counter.
// Holds the register word indices, CTRL bit positions, the POL_OE field
// offsets, the counter FSM state type and the byte-lane write mask helper.
package tqvp_ptc_pkg;

  // Word indices (address[5:2]) of the register map
  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_PERIOD   = 4'd1;
  localparam logic [3:0] REG_CNTR     = 4'd2;
  localparam logic [3:0] REG_INT_EN   = 4'd3;
  localparam logic [3:0] REG_INT_STAT = 4'd4;
  localparam logic [3:0] REG_POL_OE   = 4'd5;
  localparam int         REG_CMP0     = 8;

  // CTRL bit positions
  localparam int CTRL_EN        = 0;
  localparam int CTRL_CENTER    = 1;
  localparam int CTRL_ONESHOT   = 2;
  localparam int CTRL_CNTRRST   = 3;
  localparam int CTRL_GATE      = 4;
  localparam int CTRL_PRESC_LSB = 8;

  // POL_OE field offsets
  localparam int POL_LSB = 0;
  localparam int OE_LSB  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } cnt_state_e;

  // Bits touched by a write of the given size; 11 (no write) touches nothing.
  function automatic logic [31:0] wr_mask(input logic [1:0] wn);
    case (wn)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      2'b10:   return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_ptc_chan.sv
// One PWM compare channel.
// Ports:
//   clk, rst_n       clock / async active-low reset
//   wr_i             write strobe for this channel's CMP register
//   wdata_i, wmask_i write data and byte-lane mask
//   load_i           copy shadow CMP into the active CMP
//   tick_i           counter advanced this cycle
//   idle_i           counter FSM is idle (forces raw output inactive)
//   cnt_i, cnt_nx_i  current counter and its next value
//   pol_i            1 = active-low output
//   shadow_o         shadow CMP (register readback)
//   ev_o             registered compare event
//   pwm_o            registered PWM output (before output enable)
module tqvp_ptc_chan
  import tqvp_ptc_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [CW-1:0] wdata_i,
  input  logic [CW-1:0] wmask_i,
  input  logic          load_i,
  input  logic          tick_i,
  input  logic          idle_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [CW-1:0] cnt_nx_i,
  input  logic          pol_i,
  output logic [CW-1:0] shadow_o,
  output logic          ev_o,
  output logic          pwm_o
);

  logic [CW-1:0] shadow_q, shadow_d, act_q, act_d;
  logic          ev_q, ev_d, pwm_q, pwm_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_i) shadow_d = (shadow_q & ~wmask_i) | (wdata_i & wmask_i);
    act_d = load_i ? shadow_q : act_q;
    // Event on the tick that lands the counter on the compare value; the
    // pre-copy active value is used so a period event compares against the
    // period that is ending.
    ev_d  = tick_i && (cnt_nx_i == act_q);
    pwm_d = (!idle_i && (cnt_i < act_q)) ^ pol_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      act_q    <= '0;
      ev_q     <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      ev_q     <= ev_d;
      pwm_q    <= pwm_d;
    end
  end

  assign shadow_o = shadow_q;
  assign ev_o     = ev_q;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/tqvp_ptc_multich.sv
// Multi-channel PWM timer/counter for the TinyQV peripheral bus.
// A shared prescaled counter (edge or center aligned, optional one-shot)
// drives NCH double-buffered compare channels on uo_out[4+i].
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   ui_in                          ui_in[0] is the external count gate
//   uo_out                         PWM pins on [4+NCH-1:4], others 0
//   address, data_in               byte address in slot, write data
//   data_write_n, data_read_n      bus strobes (11 = idle)
//   data_out, data_ready           combinational zero-wait read path
//   user_interrupt                 OR of enabled interrupt status bits
module tqvp_ptc_multich
  import tqvp_ptc_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic [3:0]    widx;
  logic          wr;
  logic [31:0]   wm;
  logic [CW-1:0] wm_cw;
  logic          wr_ctrl, wr_per, wr_cntr, wr_ien, wr_stat, wr_poe, cntrrst;

  logic [15:0]   ctrl_q, ctrl_d;
  logic [7:0]    psc_q, psc_d;
  logic [CW-1:0] cnt_q, cnt_d, per_sh_q, per_act_q;
  cnt_state_e    state_q, state_d, step_st;
  logic          run, hit, tick, per_ev, per_ev_q, idle, load;
  logic [NCH:0]  ien_q, stat_q, stat_d, stat_clr;
  logic [NCH-1:0] pol_q, oe_q, cmp_ev, pwm_v;
  logic [NCH-1:0][CW-1:0] cmp_sh;
  logic [31:0]   rd;

  // ---------------- bus decode ----------------
  assign widx    = address[5:2];
  assign wr      = (data_write_n != 2'b11);
  assign wm      = wr_mask(data_write_n);
  assign wm_cw   = wm[CW-1:0];
  assign wr_ctrl = wr && (widx == REG_CTRL);
  assign wr_per  = wr && (widx == REG_PERIOD);
  assign wr_cntr = wr && (widx == REG_CNTR);
  assign wr_ien  = wr && (widx == REG_INT_EN);
  assign wr_stat = wr && (widx == REG_INT_STAT);
  assign wr_poe  = wr && (widx == REG_POL_OE);
  assign cntrrst = wr_ctrl && wm[CTRL_CNTRRST] && data_in[CTRL_CNTRRST];

  // ---------------- prescaler ----------------
  // Held at 0 while disabled, so an EN 0->1 always starts a fresh period.
  // ">=" keeps it wrapping sanely if PRESC is lowered below the count.
  assign run  = ctrl_q[CTRL_EN] && (!ctrl_q[CTRL_GATE] || ui_in[0]);
  assign hit  = run && (psc_q >= ctrl_q[CTRL_PRESC_LSB +: 8]);
  assign tick = hit && !wr_cntr && !cntrrst;

  always_comb begin
    psc_d = psc_q;
    if (!ctrl_q[CTRL_EN] || wr_cntr || cntrrst || hit) psc_d = '0;
    else if (run) psc_d = psc_q + 8'd1;
  end

  // ---------------- counter datapath ----------------
  always_comb begin
    cnt_d   = cnt_q;
    step_st = state_q;
    per_ev  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_UP: begin
          if (cnt_q >= per_act_q) begin
            // Center mode with PERIOD<=1 has no room to run down; wrap
            // directly so the cycle is still 2*PERIOD ticks.
            if (!ctrl_q[CTRL_CENTER] || cnt_q <= CW'(1)) begin
              cnt_d  = '0;
              per_ev = 1'b1;
            end else begin
              cnt_d   = cnt_q - 1'b1;
              step_st = ST_DOWN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DOWN: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            per_ev  = 1'b1;
            step_st = ST_UP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (wr_cntr) cnt_d = (cnt_q & ~wm_cw) | (data_in[CW-1:0] & wm_cw);
    if (cntrrst) cnt_d = '0;
  end

  // ---------------- CTRL ----------------
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) ctrl_d = (ctrl_q & ~wm[15:0]) | (data_in[15:0] & wm[15:0]);
    else if (per_ev && ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
    ctrl_d[CTRL_CNTRRST] = 1'b0;
    ctrl_d[7:5]          = 3'b000;
  end

  // ---------------- counter FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The FSM follows the next EN value, so it leaves IDLE on the same edge
  // that enables the timer and returns to it on the edge EN clears.
  always_comb begin
    if (!ctrl_d[CTRL_EN])                       state_d = ST_IDLE;
    else if (state_q == ST_IDLE || cntrrst)     state_d = ST_UP;
    else                                        state_d = step_st;
  end

  always_comb begin
    idle = (state_q == ST_IDLE);
    load = idle || per_ev;
  end

  // ---------------- registers ----------------
  always_comb begin
    stat_clr = wr_stat ? (data_in[NCH:0] & wm[NCH:0]) : '0;
    // Set wins over a simultaneous clear.
    stat_d   = (stat_q & ~stat_clr) | {per_ev_q, cmp_ev};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      psc_q     <= '0;
      cnt_q     <= '0;
      per_sh_q  <= '0;
      per_act_q <= '0;
      per_ev_q  <= 1'b0;
      ien_q     <= '0;
      stat_q    <= '0;
      pol_q     <= '0;
      oe_q      <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      psc_q    <= psc_d;
      cnt_q    <= cnt_d;
      per_ev_q <= per_ev;
      stat_q   <= stat_d;
      if (wr_per) per_sh_q <= (per_sh_q & ~wm_cw) | (data_in[CW-1:0] & wm_cw);
      if (load)   per_act_q <= per_sh_q;
      if (wr_ien) ien_q <= (ien_q & ~wm[NCH:0]) | (data_in[NCH:0] & wm[NCH:0]);
      if (wr_poe) begin
        pol_q <= (pol_q & ~wm[POL_LSB +: NCH]) | (data_in[POL_LSB +: NCH] & wm[POL_LSB +: NCH]);
        oe_q  <= (oe_q  & ~wm[OE_LSB  +: NCH]) | (data_in[OE_LSB  +: NCH] & wm[OE_LSB  +: NCH]);
      end
    end
  end

  // ---------------- channels ----------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tqvp_ptc_chan #(.CW(CW)) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (wr && (widx == 4'(REG_CMP0 + g))),
      .wdata_i  (data_in[CW-1:0]),
      .wmask_i  (wm_cw),
      .load_i   (load),
      .tick_i   (tick),
      .idle_i   (idle),
      .cnt_i    (cnt_q),
      .cnt_nx_i (cnt_d),
      .pol_i    (pol_q[g]),
      .shadow_o (cmp_sh[g]),
      .ev_o     (cmp_ev[g]),
      .pwm_o    (pwm_v[g])
    );
  end

  // ---------------- read path / outputs ----------------
  always_comb begin
    rd = '0;
    case (widx)
      REG_CTRL:     rd[15:0]   = ctrl_q;
      REG_PERIOD:   rd[CW-1:0] = per_sh_q;
      REG_CNTR:     rd[CW-1:0] = cnt_q;
      REG_INT_EN:   rd[NCH:0]  = ien_q;
      REG_INT_STAT: rd[NCH:0]  = stat_q;
      REG_POL_OE: begin
        rd[POL_LSB +: NCH] = pol_q;
        rd[OE_LSB  +: NCH] = oe_q;
      end
      default: begin
        for (int i = 0; i < NCH; i++)
          if (widx == 4'(REG_CMP0 + i)) rd[CW-1:0] = cmp_sh[i];
      end
    endcase
  end

  assign data_ready     = (data_read_n != 2'b11);
  assign data_out       = data_ready ? rd : 32'h0;
  assign user_interrupt = |(stat_q & ien_q);
  assign uo_out         = {4'(pwm_v & oe_q), 4'b0000};

  logic unused_bits;
  assign unused_bits = ^{ui_in[7:1], address[1:0], data_in[31:16], wm[31:16]};

endmodule

// File: doc/tqvp_ptc_multich.md
# tqvp_ptc_multich

Multi-channel PWM timer/counter peripheral for the TinyQV peripheral bus, successor to the single-channel PTC. One shared prescaled counter drives NCH double-buffered compare channels, with edge-aligned or center-aligned counting, one-shot mode, per-channel polarity and output enable, and a write-1-to-clear interrupt status register. It occupies one 64-byte peripheral slot and drives PWM pins on uo_out[7:4].

## Interface
- NCH, 4, number of PWM channels, 1..4
- CW, 16, counter, period and compare width, 8..24
- clk  in  1  project clock, 64 MHz nominal
- rst_n  in  1  asynchronous active-low reset
- ui_in  in  8  input PMOD; ui_in[0] is external count enable when CTRL.GATE=1
- uo_out  out  8  uo_out[4+i] = PWM channel i when OE[i]=1, else 0; bits [3:0] and unused channel bits are 0
- address  in  6  byte address within slot; word index = address[5:2]
- data_in  in  32  write data
- data_write_n  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit
- data_read_n  in  2  11 none, 00/01/10 read
- data_out  out  32  read data, 0 when no read
- data_ready  out  1  1 in any cycle with data_read_n != 11 (zero-wait reads)
- user_interrupt  out  1  OR of (INT_STAT & INT_EN)

## Operation
- Register map, word offsets: 0x00 CTRL; 0x04 PERIOD; 0x08 CNTR; 0x0C INT_EN; 0x10 INT_STAT; 0x14 POL_OE; 0x20+4i CMP[i]. Unmapped offsets read 0, writes ignored.
- CTRL: [0] EN, [1] CENTER, [2] ONESHOT, [3] CNTRRST (self-clearing, reads 0), [4] GATE, [15:8] PRESC.
- POL_OE: [NCH-1:0] POL (1 = active-low), [8+NCH-1:8] OE.
- INT_EN/INT_STAT: bit i = compare match of channel i; bit NCH = period event.
- Byte lanes: 8-bit writes update bits [7:0] only, 16-bit writes update [15:0], 32-bit writes update all bits. Upper bits are retained.
- Tick: prescaler emits one tick every PRESC+1 clk cycles while EN=1 and (GATE=0 or ui_in[0]=1). The prescaler is cleared on EN 0->1, on a CNTR write and on CNTRRST.
- Counter FSM states: IDLE (EN=0), UP, DOWN.
  - Edge mode: UP only. On tick, if cnt >= PERIOD_act then cnt<=0 and a period event occurs; otherwise cnt+1.
  - Center mode: UP until cnt >= PERIOD_act, then DOWN. DOWN runs to 0, then the period event occurs and the FSM returns to UP. The full cycle is 2*PERIOD ticks.
- Shadowing: PERIOD and CMP writes land in shadow registers. Shadow values copy to the active registers on each period event and continuously while in IDLE.
- Output: raw_i = (cnt < CMP_act[i]); pwm_i = raw_i ^ POL[i]. CMP=0 gives constant inactive; CMP>PERIOD gives constant active. In IDLE, raw_i=0.
- Compare event for channel i: a tick on which cnt becomes equal to CMP_act[i], in either direction.
- ONESHOT: at the first period event EN clears, the FSM goes to IDLE and cnt=0.
- CNTRRST: cnt=0, FSM=UP, prescaler cleared. No period event is generated.
- CNTR write: loads cnt on the next edge. The FSM keeps its direction.
- INT_STAT: a bit sets on its event; writing 1 clears it. If an event and a clear hit the same bit in the same cycle, set wins.
- EN cleared by software: FSM goes to IDLE; cnt holds its value until the next write or CNTRRST.

## Timing
- Reset: all registers 0, FSM IDLE; uo_out=0, data_out=0, data_ready=0, user_interrupt=0.
- Register writes take effect on the clk edge of the write cycle.
- data_out is combinational from address. data_ready is high in the same cycle as the read request.
- cnt updates on the tick edge. pwm outputs and INT_STAT are registered one cycle after the cnt update.
- user_interrupt is combinational from INT_STAT and INT_EN.
- Shadow-to-active copy happens on the same edge as the period event, so the new CMP governs the first cycle of the next period.
- Asserting rst_n low mid-period returns every state to its reset value immediately.

## Structure
- Package tqvp_ptc_pkg holds: register offset localparams, CTRL bit indices, the FSM enum (IDLE/UP/DOWN), and the POL_OE field offsets.
- Sub-module tqvp_ptc_chan (one per channel, generate loop) holds the shadow and active CMP registers, the compare/event logic and the output register.
- The top level holds the bus decode, prescaler, counter FSM, PERIOD, INT logic and the uo_out mapping.

## Test plan
- Edge mode, PRESC=0, PERIOD=9, CMP0=3, OE0=1 -> uo_out[4] high 3 ticks and low 7 ticks, repeating every 10 clk; period event every 10 clk.
- Center mode, PERIOD=8, CMP1=2, POL1=1 -> 16-tick period; uo_out[5] low only while cnt<2 (ticks 0,1 and 15); compare events at cnt=2 going up and going down.
- Shadow: CMP0 changed from 3 to 6 mid-period -> width stays 3 until the period event, then becomes 6.
- ONESHOT, PERIOD=4, INT_EN bit NCH=1 -> exactly one period event, EN reads 0, user_interrupt=1; W1C write of 0x10 clears user_interrupt.
- PRESC=3, GATE=1, ui_in[0] low for 8 cycles -> cnt frozen for those cycles; otherwise increments every 4 clk.
- Edge cases: CMP=0 gives constant inactive; CMP=PERIOD+1 gives constant active; 8-bit write of 0xFF to PERIOD leaves bits [15:8] unchanged; rst_n pulse mid-run gives all outputs 0.
